icache_fill_ctrl: RTL and testbench

Miss-handling fill controller that sits directly upstream of the instruction cache.
- On a cache miss it streams the 8-word (16-byte) block containing the miss address from the multi-cycle instruction memory into the cache data array, one word per returned beat.
- It raises the tag-array write on the final word.
- It holds fsm_busy so the pipeline stalls fetch until the block is resident.

---
 rtl/icache_fill_ctrl_pkg.sv | 35 +++
 rtl/icache_fill_ctrl_fill_word_counter.sv | 36 +++
 rtl/icache_fill_ctrl.sv | 117 +++++++++++
 tb/tb_icache_fill_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_fill_ctrl_pkg.sv
// Shared definitions for the instruction-cache fill controller.
// Holds the FSM state encoding, address-geometry constants (also used by the
// cache tag decode) and a helper that forms the byte address of a word in a block.
package icache_fill_ctrl_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK);

  // Address geometry: 16-byte blocks of 16-bit words.
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_OFFSET_LSB   = 1;
  localparam int TAG_MSB           = 15;
  localparam int TAG_LSB           = 10;
  localparam int INDEX_MSB         = 9;
  localparam int INDEX_LSB         = 4;

  // Clears the block-offset bits of an address to give the block base.
  localparam logic [ADDR_W-1:0] BLOCK_BASE_MASK =
    ~ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Byte address of word idx inside the block at base. base has its offset
  // bits clear, so the add never carries into the index/tag fields.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + (ADDR_W'(idx) << WORD_OFFSET_LSB);
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_fill_word_counter.sv
// fill_word_counter: word counter for one side (issue or receive) of a fill.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   clr  - synchronous clear (wins over en)
//   en   - count up by one this cycle
//   cnt  - current count
//   tc   - terminal count (cnt is all ones, i.e. last word of the block)
module fill_word_counter
  import icache_fill_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = &cnt;

endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: miss-handling fill controller for the instruction cache.
// On a miss it issues 8 consecutive word reads for the containing block,
// writes each returned word into the data array and writes the tag array on
// the last word, holding fsm_busy until the block is resident.
// Ports:
//   clk, rst                         - clock, asynchronous active-low reset
//   miss_detected, miss_address      - miss request from fetch
//   memory_data_valid, memory_data   - returned word from instruction memory
//   fsm_busy                         - fill in progress (stall fetch)
//   memory_read, memory_address      - read request to memory
//   write_data_array, cache_write_addr, cache_write_data - data array write
//   write_tag_array                  - tag/metadata write, one pulse per fill
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_write_addr,
  output logic [DATA_W-1:0] cache_write_data
);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic              issue_done_q;
  logic [CNT_W-1:0]  issue_cnt, recv_cnt;
  logic              issue_tc, recv_tc;
  logic              start, issue_en, recv_en;

  // A miss is only accepted from IDLE; misses during FILL are ignored.
  assign start    = (state_q == IDLE) && miss_detected;
  // Issue and receive run independently: requests go out back to back
  // while returned beats are counted as they arrive.
  assign issue_en = (state_q == FILL) && !issue_done_q;
  assign recv_en  = (state_q == FILL) && memory_data_valid;

  fill_word_counter #(.W(CNT_W)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (issue_en),
    .cnt (issue_cnt),
    .tc  (issue_tc)
  );

  fill_word_counter #(.W(CNT_W)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (recv_en),
    .cnt (recv_cnt),
    .tc  (recv_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      issue_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        base_q       <= miss_address & BLOCK_BASE_MASK;
        issue_done_q <= 1'b0;
      end else if (issue_en && issue_tc) begin
        // Last request of the block has gone out; the issue counter wraps
        // to 0 but stays idle until the next fill.
        issue_done_q <= 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_write_addr = '0;
    cache_write_data = '0;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) state_d = FILL;
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_done_q) begin
          memory_read    = 1'b1;
          memory_address = word_addr(base_q, issue_cnt);
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          cache_write_addr = word_addr(base_q, recv_cnt);
          cache_write_data = memory_data;
          // The 8th beat completes the block: validate it and release fetch.
          if (recv_tc) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: a directed per-cycle vector table
// for the first fill, then hand-written sequences driven by a small
// fixed-latency memory model that returns data equal to the address.
module tb_icache_fill_ctrl;

  localparam int MEM_LATENCY = 4;
  // Requests in cycles 1..8 return data in cycles 4..11.
  localparam int PIPE_D = MEM_LATENCY - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        fsm_busy, memory_read, write_data_array, write_tag_array;
  logic [15:0] memory_address, cache_write_addr, cache_write_data;

  always #5 clk = ~clk;

  icache_fill_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .cache_write_addr  (cache_write_addr),
    .cache_write_data  (cache_write_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tot_wr   = 0;
  int tot_tag  = 0;

  logic        pv [PIPE_D];
  logic [15:0] pa [PIPE_D];
  logic [51:0] obs;

  typedef struct {
    logic        miss;
    logic [15:0] maddr;
    logic        mv;
    logic [15:0] md;
    logic [51:0] exp_out;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [51:0] pk(input logic b, input logic rd, input logic [15:0] ma,
                                     input logic wd, input logic wt,
                                     input logic [15:0] wa, input logic [15:0] wdat);
    return {b, rd, ma, wd, wt, wa, wdat};
  endfunction

  function automatic logic [51:0] cur_out();
    return {fsm_busy, memory_read, memory_address, write_data_array,
            write_tag_array, cache_write_addr, cache_write_data};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs change 1 time unit after the rising edge,
  // outputs are sampled on the falling edge and fed to the memory model.
  task automatic tick(input logic miss, input logic [15:0] addr,
                      input logic use_model, input logic mv, input logic [15:0] md);
    logic        ov;
    logic [15:0] oa;
    @(posedge clk);
    #1;
    ov = pv[PIPE_D-1];
    oa = pa[PIPE_D-1];
    for (int i = PIPE_D - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = 1'b0;
    pa[0] = '0;
    miss_detected = miss;
    miss_address  = addr;
    if (use_model) begin
      memory_data_valid = ov;
      memory_data       = ov ? oa : 16'h0000;
    end else begin
      memory_data_valid = mv;
      memory_data       = md;
    end
    @(negedge clk);
    obs   = cur_out();
    pv[0] = memory_read;
    pa[0] = memory_address;
  endtask

  // Full fill through the memory model; returns right after the tag-write
  // cycle so a following call starts on the first IDLE cycle.
  task automatic run_fill(input string tag, input logic [15:0] addr);
    logic [15:0] base;
    int n_req, n_wr, n_tag, busy_cyc;
    bit done;
    base = addr & 16'hFFF0;
    n_req = 0; n_wr = 0; n_tag = 0; busy_cyc = 0; done = 0;
    tick(1'b1, addr, 1'b1, 1'b0, 16'h0);
    check({tag, "_idle_at_miss"}, 64'(fsm_busy), 64'd0);
    for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
      tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      if (fsm_busy) busy_cyc++;
      if (memory_read) begin
        check({tag, "_req_addr"}, 64'(memory_address), 64'(base + 16'(n_req * 2)));
        n_req++;
      end
      if (write_data_array) begin
        check({tag, "_wr_addr"}, 64'(cache_write_addr), 64'(base + 16'(n_wr * 2)));
        check({tag, "_wr_data"}, 64'(cache_write_data), 64'(base + 16'(n_wr * 2)));
        n_wr++;
        tot_wr++;
      end
      if (write_tag_array) begin
        n_tag++;
        tot_tag++;
        check({tag, "_tag_on_8th_beat"}, 64'(n_wr), 64'd8);
        done = 1;
      end
    end
    check({tag, "_completed"}, 64'(done), 64'd1);
    check({tag, "_n_requests"}, 64'(n_req), 64'd8);
    check({tag, "_n_writes"}, 64'(n_wr), 64'd8);
    check({tag, "_n_tag_pulses"}, 64'(n_tag), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_seen;
    for (int i = 0; i < PIPE_D; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end

    // Cycle-by-cycle vectors for a miss at 0x1234, memory latency 4.
    // A second miss (0x4000) in cycle 3 must be ignored; a stray beat
    // (0xDEAD) in IDLE after completion must not write.
    vecs[0]  = '{1'b1, 16'h1234, 1'b0, 16'h0000, pk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000)};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, pk(1, 1, 16'h1230, 0, 0, 16'h0000, 16'h0000)};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, pk(1, 1, 16'h1232, 0, 0, 16'h0000, 16'h0000)};
    vecs[3]  = '{1'b1, 16'h4000, 1'b0, 16'h0000, pk(1, 1, 16'h1234, 0, 0, 16'h0000, 16'h0000)};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 16'h1230, pk(1, 1, 16'h1236, 1, 0, 16'h1230, 16'h1230)};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 16'h1232, pk(1, 1, 16'h1238, 1, 0, 16'h1232, 16'h1232)};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h1234, pk(1, 1, 16'h123A, 1, 0, 16'h1234, 16'h1234)};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 16'h1236, pk(1, 1, 16'h123C, 1, 0, 16'h1236, 16'h1236)};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 16'h1238, pk(1, 1, 16'h123E, 1, 0, 16'h1238, 16'h1238)};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 16'h123A, pk(1, 0, 16'h0000, 1, 0, 16'h123A, 16'h123A)};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'h123C, pk(1, 0, 16'h0000, 1, 0, 16'h123C, 16'h123C)};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 16'h123E, pk(1, 0, 16'h0000, 1, 1, 16'h123E, 16'h123E)};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, pk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000)};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 16'hDEAD, pk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000)};

    // Reset state, with live-looking inputs to show they do not leak out.
    memory_data_valid = 1'b1;
    memory_data       = 16'hBEEF;
    miss_detected     = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(cur_out()), 64'd0);
    memory_data_valid = 1'b0;
    memory_data       = '0;
    miss_detected     = 1'b0;
    rst = 1'b1;
    tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    check("idle_after_reset", 64'(obs), 64'd0);

    for (int i = 0; i < 14; i++) begin
      tick(vecs[i].miss, vecs[i].maddr, 1'b0, vecs[i].mv, vecs[i].md);
      check($sformatf("vec_cycle_%0d", i), 64'(obs), 64'(vecs[i].exp_out));
    end

    // Top-of-memory block: no carry out of the offset field.
    run_fill("top_block", 16'hFFFE);
    tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    check("top_block_idle_after", 64'(fsm_busy), 64'd0);

    // Reset after 3 valid beats.
    wr_seen = 0;
    tick(1'b1, 16'h2000, 1'b1, 1'b0, 16'h0);
    for (int c = 1; c <= 6; c++) begin
      tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      if (write_data_array) wr_seen++;
    end
    check("rst_mid_beats_before", 64'(wr_seen), 64'd3);
    check("rst_mid_busy_before", 64'(fsm_busy), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_outputs_immediate", 64'(cur_out()), 64'd0);
    @(negedge clk);
    check("rst_mid_no_tag", 64'(write_tag_array), 64'd0);
    check("rst_mid_state_idle", 64'(dut.state_q), 64'd0);
    rst = 1'b1;
    // In-flight beats from the aborted fill land in IDLE and must not write.
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      check("rst_stale_beat_ignored", 64'({write_data_array, write_tag_array, fsm_busy}), 64'd0);
    end
    run_fill("after_rst", 16'h0040);

    // Back-to-back misses: second one on the first IDLE cycle.
    tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    tot_wr  = 0;
    tot_tag = 0;
    run_fill("b2b_first", 16'h0100);
    run_fill("b2b_second", 16'h0200);
    check("b2b_total_writes", 64'(tot_wr), 64'd16);
    check("b2b_total_tags", 64'(tot_tag), 64'd2);
    tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    check("b2b_idle_after", 64'(obs), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
